// File: rtl/rv32i_decode_stage.sv
// rv32i_types: RV32I instruction layout, opcode/funct enums and the decode bundle.
// rv32i_decode_stage: RV32I decode stage with a two-entry skid buffer.
//   Fetch side : in_valid/in_ready handshake, in_instr (raw word), in_pc (sideband).
//   Exec side  : out_valid/out_ready handshake, registered decode bundle out_*
//                (pc, opcode, rd, rs1, rs2, funct3, funct7, imm, rd_we, illegal).
//   Control    : clk, rst_n (async active-low), flush (synchronous kill of entries).
//   Option     : DECODE_ILLEGAL_CNT_EN adds illegal_cnt[15:0], a saturating count
//                of illegal bundles handed to execute (cleared only by rst_n).
package rv32i_types;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_IMM    = 7'b0010011,
        OPC_REG    = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } rv32i_opcode;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SRL_SRA = 3'b101
    } rv32i_funct3;

    typedef enum logic [6:0] {
        F7_BASE    = 7'b0000000,
        F7_VARIANT = 7'b0100000
    } rv32i_funct7;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        rd_we;
        logic        illegal;
    } dec_t;

endpackage

module rv32i_decode_stage
    import rv32i_types::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [31:0]     out_imm,
    output logic            out_rd_we,
    output logic            out_illegal
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]     illegal_cnt
`endif
);

    instr_t            ins;
    dec_t              dec;
    logic              illegal;
    logic [31:0]       imm;

    dec_t              or_q, or_d, sr_q, sr_d;
    logic [PC_W-1:0]   or_pc_q, or_pc_d, sr_pc_q, sr_pc_d;
    logic              or_valid_q, or_valid_d, sr_valid_q, sr_valid_d;
    logic              in_ready_q;
    logic              accept, xfer;

    assign ins = instr_t'(in_instr);

    // Combinational decode of the incoming word: legality and immediate.
    always_comb begin
        illegal = 1'b0;
        imm     = 32'd0;
        case (ins.opcode)
            OPC_LOAD: begin
                illegal = (ins.funct3 == 3'b011) || (ins.funct3 == 3'b110) ||
                          (ins.funct3 == 3'b111);
                imm     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_STORE: begin
                illegal = (ins.funct3 > 3'b010);
                imm     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                illegal = (ins.funct3 == 3'b010) || (ins.funct3 == 3'b011);
                imm     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OPC_JALR: begin
                illegal = (ins.funct3 != 3'b000);
                imm     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_JAL: begin
                imm     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            OPC_IMM: begin
                // Shift-immediates reuse funct7 as an encoding qualifier.
                if (ins.funct3 == F3_SLL)
                    illegal = (ins.funct7 != F7_BASE);
                else if (ins.funct3 == F3_SRL_SRA)
                    illegal = (ins.funct7 != F7_BASE) && (ins.funct7 != F7_VARIANT);
                imm     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OPC_REG: begin
                // Only add/sub and srl/sra have a funct7 variant.
                if (ins.funct7 == F7_VARIANT)
                    illegal = (ins.funct3 != F3_ADD_SUB) && (ins.funct3 != F3_SRL_SRA);
                else
                    illegal = (ins.funct7 != F7_BASE);
            end
            OPC_LUI, OPC_AUIPC: begin
                imm     = {in_instr[31:12], 12'd0};
            end
            default: illegal = 1'b1;
        endcase
        if (illegal)
            imm = 32'd0;
    end

    always_comb begin
        dec.opcode  = ins.opcode;
        dec.rd      = ins.rd;
        dec.rs1     = ins.rs1;
        dec.rs2     = ins.rs2;
        dec.funct3  = ins.funct3;
        dec.funct7  = ins.funct7;
        dec.imm     = imm;
        dec.illegal = illegal;
        dec.rd_we   = !illegal && (ins.rd != 5'd0) &&
                      (ins.opcode != OPC_BRANCH) && (ins.opcode != OPC_STORE);
    end

    assign accept = in_valid && in_ready_q;
    assign xfer   = or_valid_q && out_ready;

    // Skid buffer next state: SR always drains into OR before new words.
    always_comb begin
        or_d       = or_q;
        or_pc_d    = or_pc_q;
        or_valid_d = or_valid_q;
        sr_d       = sr_q;
        sr_pc_d    = sr_pc_q;
        sr_valid_d = sr_valid_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sr_valid_d = 1'b0;
        end else if (!or_valid_q || out_ready) begin
            if (sr_valid_q) begin
                or_d       = sr_q;
                or_pc_d    = sr_pc_q;
                or_valid_d = 1'b1;
                sr_valid_d = accept;
                if (accept) begin
                    sr_d    = dec;
                    sr_pc_d = in_pc;
                end
            end else begin
                or_valid_d = accept;
                if (accept) begin
                    or_d    = dec;
                    or_pc_d = in_pc;
                end
            end
        end else if (accept) begin
            sr_d       = dec;
            sr_pc_d    = in_pc;
            sr_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q       <= '0;
            or_pc_q    <= '0;
            or_valid_q <= 1'b0;
            sr_q       <= '0;
            sr_pc_q    <= '0;
            sr_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            or_q       <= or_d;
            or_pc_q    <= or_pc_d;
            or_valid_q <= or_valid_d;
            sr_q       <= sr_d;
            sr_pc_q    <= sr_pc_d;
            sr_valid_q <= sr_valid_d;
            in_ready_q <= !sr_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = or_valid_q;
    assign out_pc      = or_pc_q;
    assign out_opcode  = or_q.opcode;
    assign out_rd      = or_q.rd;
    assign out_rs1     = or_q.rs1;
    assign out_rs2     = or_q.rs2;
    assign out_funct3  = or_q.funct3;
    assign out_funct7  = or_q.funct7;
    assign out_imm     = or_q.imm;
    assign out_rd_we   = or_q.rd_we;
    assign out_illegal = or_q.illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of illegal bundles taken by execute; flush does not clear it.
    always_comb begin
        cnt_d = cnt_q;
        if (xfer && or_q.illegal && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 16'd0;
        else
            cnt_q <= cnt_d;
    end

    assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed testbench for rv32i_decode_stage: decode vectors, backpressure,
// flush and asynchronous reset, all checked against hand-computed values.
module tb_rv32i_decode_stage;

    localparam int unsigned PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [31:0]     out_imm;
    logic            out_rd_we;
    logic            out_illegal;
`ifdef DECODE_ILLEGAL_CNT_EN
    logic [15:0]     illegal_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32i_decode_stage #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_rd_we   (out_rd_we),
        .out_illegal (out_illegal)
`ifdef DECODE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic        ill;
    } vec_t;

    vec_t vecs [12];
    int   n_ill;

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 5'd1,  1'b1, 1'b0}; // addi x1,x0,-1
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 5'd29, 1'b0, 1'b0}; // beq x0,x0,-4
        vecs[2]  = '{32'h123452B7, 32'h12345000, 5'd5,  1'b1, 1'b0}; // lui x5
        vecs[3]  = '{32'h00002063, 32'h00000000, 5'd0,  1'b0, 1'b1}; // branch f3=010
        vecs[4]  = '{32'h40001033, 32'h00000000, 5'd0,  1'b0, 1'b1}; // sll with variant
        vecs[5]  = '{32'h00112223, 32'h00000004, 5'd4,  1'b0, 1'b0}; // sw x1,4(x2)
        vecs[6]  = '{32'h008000EF, 32'h00000008, 5'd1,  1'b1, 1'b0}; // jal x1,+8
        vecs[7]  = '{32'h4020D1B3, 32'h00000000, 5'd3,  1'b1, 1'b0}; // sra x3,x1,x2
        vecs[8]  = '{32'h0000000F, 32'h00000000, 5'd0,  1'b0, 1'b1}; // fence: not base
        vecs[9]  = '{32'h00000013, 32'h00000000, 5'd0,  1'b0, 1'b0}; // nop, rd=x0
        vecs[10] = '{32'h00003003, 32'h00000000, 5'd0,  1'b0, 1'b1}; // load f3=011
        vecs[11] = '{32'h4010D093, 32'h00000401, 5'd1,  1'b1, 1'b0}; // srai x1,x1,1

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_imm",   out_imm,        32'd0);
        check("rst_out_pc",    out_pc,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Decode table: one word per cycle, execute always ready.
        n_ill = 0;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = 32'h100 + 32'(i * 4);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_valid", i),   32'(out_valid),   32'd1);
            check($sformatf("v%0d_pc", i),      out_pc,           32'h100 + 32'(i * 4));
            check($sformatf("v%0d_imm", i),     out_imm,          vecs[i].imm);
            check($sformatf("v%0d_rd", i),      32'(out_rd),      32'(vecs[i].rd));
            check($sformatf("v%0d_rd_we", i),   32'(out_rd_we),   32'(vecs[i].rd_we));
            check($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
            check($sformatf("v%0d_opcode", i),  32'(out_opcode),  32'(vecs[i].instr & 32'h7F));
            check($sformatf("v%0d_f3", i),      32'(out_funct3),  (vecs[i].instr >> 12) & 32'h7);
            check($sformatf("v%0d_f7", i),      32'(out_funct7),  vecs[i].instr >> 25);
            check($sformatf("v%0d_rs1", i),     32'(out_rs1),     (vecs[i].instr >> 15) & 32'h1F);
            check($sformatf("v%0d_rs2", i),     32'(out_rs2),     (vecs[i].instr >> 20) & 32'h1F);
            if (vecs[i].ill) n_ill++;
        end
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("illegal_cnt", 32'(illegal_cnt), 32'd4);
`endif

        // Backpressure: A held in OR, B in SR, C stalls until execute drains.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'hA00;
        tick();
        in_pc = 32'hB00;
        tick();
        in_pc = 32'hC00;
        check("bp_full_in_ready", 32'(in_ready),  32'd0);
        check("bp_full_pc",       out_pc,         32'hA00);
        tick();
        check("bp_stall_in_ready", 32'(in_ready), 32'd0);
        check("bp_stall_pc",       out_pc,        32'hA00);
        check("bp_stall_valid",    32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_b_pc",       out_pc,        32'hB00);
        check("bp_b_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_c_pc",    out_pc,         32'hC00);
        check("bp_c_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp_drain_valid", 32'(out_valid), 32'd0);
        check("bp_in_ready",    32'(in_ready),  32'd1);

        // Flush with OR and SR full and a word presented in the same cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'hD00;
        tick();
        in_pc = 32'hE00;
        tick();
        in_pc = 32'hF00; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid",    32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        tick();
        check("fl_after_valid", 32'(out_valid), 32'd0);

        // Flush with OR holding a word and SR empty: the accepted word is discarded.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h1100;
        tick();
        in_pc = 32'h1200; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl2_valid", 32'(out_valid), 32'd0);
        tick();
        check("fl2_after_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream, then a single word after release.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h2000;
        tick();
        in_pc = 32'h2100;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid",    32'(out_valid), 32'd0);
        check("ar_in_ready", 32'(in_ready),  32'd1);
        check("ar_pc",       out_pc,         32'd0);
        check("ar_imm",      out_imm,        32'd0);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("ar_cnt",      32'(illegal_cnt), 32'd0);
`endif
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h3000;
        tick();
        in_valid = 1'b0;
        check("ar_first_valid", 32'(out_valid), 32'd1);
        check("ar_first_pc",    out_pc,         32'h3000);
        check("ar_first_imm",   out_imm,        32'h12345000);
        tick();
        check("ar_alone_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- Pipeline decode stage that consumes raw RV32I instruction words from fetch and produces registered, field-split, immediate-expanded decode bundles for execute.
- Uses the team's rv32i_types package (instr_t, rv32i_opcode, funct3/funct7 enums) for field extraction.
- Two-entry skid buffer sustains one instruction per cycle under valid/ready backpressure on both sides, with a synchronous flush for redirects.

Parameters:
- PC_W, 32, width of the pc sideband carried with each instruction.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  fetch word valid
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction word (instr_t)
- in_pc  in  PC_W  pc of in_instr
- out_valid  out  1  decode bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  PC_W  pc of bundle
- out_opcode  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_imm  out  32  expanded immediate
- out_rd_we  out  1  bundle writes a register
- out_illegal  out  1  encoding not legal RV32I base (no system/fence)

Behaviour:
- Reset (async, rst_n=0): both entries invalid; out_valid=0, in_ready=1, all out_* data = 0. Takes effect mid-transfer; no partial state survives.
- Decode is combinational on in_instr and captured at accept. Latency is 1 cycle: accept at edge N gives out_valid from after edge N.
- Storage:
  - Output register (OR) drives out_*.
  - Skid register (SR) holds one overflow bundle.
  - in_ready = !SR.valid, registered (no combinational path from out_ready).
- Accept when in_valid && in_ready. Transfer when out_valid && out_ready.
- Per edge:
  - If OR is empty or transferring, OR loads SR if SR is valid, else the accepted bundle. When SR feeds OR and an accept also occurs, the accept goes to SR.
  - If OR is held (valid && !out_ready) and an accept occurs, the accept goes to SR.
  - Program order is always preserved.
- flush=1: OR.valid and SR.valid cleared at the edge, and any same-cycle accept is discarded. A same-cycle transfer still counts as completed.
- Immediates:
  - I (load, imm, jalr): sext instr[31:20]
  - S: sext {instr[31:25], instr[11:7]}
  - B: sext {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U (lui, auipc): {instr[31:12], 12'b0}
  - J: sext {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R-type and illegal: 0
- Illegal when any of:
  - opcode is not one of the nine rv32i_opcode values
  - load f3 is 011, 110 or 111
  - store f3 > 010
  - branch f3 is 010 or 011
  - jalr f3 != 000
  - reg funct7 is not base; variant is permitted only with f3 000 or 101
  - imm f3 001 with funct7 != base
  - imm f3 101 with funct7 not base or variant
- out_rd_we = !illegal && rd != 0 && opcode not br and not store.
- Field outputs are passed through even when illegal.

Optional Feature:
- Macro: DECODE_ILLEGAL_CNT_EN
- When defined:
  - Adds output illegal_cnt [15:0].
  - Increments on each transfer with out_illegal=1 and saturates at 0xFFFF.
  - Reset to 0 by rst_n only; flush does not clear it.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then 0xFFF00093 (addi x1,x0,-1), pc 0x100, out_ready=1 -> next cycle out_valid=1, rd=1, imm=0xFFFFFFFF, rd_we=1, illegal=0, pc=0x100.
- 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, rd_we=0. 0x123452B7 (lui x5) -> imm=0x12345000, rd=5, rd_we=1.
- 0x00002063 (branch f3=010) and 0x40001033 (sll with variant) -> illegal=1, rd_we=0, imm=0. With DECODE_ILLEGAL_CNT_EN, illegal_cnt=2 after both transfers.
- Back-to-back A, B, C with out_ready=0 for 3 cycles:
  - A held in OR, B in SR, in_ready=0, C stalls.
  - Raise out_ready -> A, B, C emerge on consecutive cycles, in_ready returns to 1.
- With OR and SR both full, assert flush alongside in_valid -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears at the output.
- Assert rst_n=0 asynchronously mid-stream -> out_valid drops immediately without waiting for clk; after release, first accepted word emerges alone.
